regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised multi-port register file; successor to the single 64-bit enabled register.
- Generalised in data width, register count and read-port count.
- Adds synchronous clear, a hardwired zero register and byte-lane write enables.
- Sits in the CPU datapath between instruction decode (register indices) and the ALU/memory operand muxes.
- Replaces hand-instantiated banks of 64-bit registers.

Parameters:
- WIDTH, 64, data bits per register; must be a multiple of 8.
- DEPTH, 32, number of architectural registers.
- NUM_READ, 2, number of independent combinational read ports.
- ZERO_REG, 31, index that always reads 0 and ignores writes (X31/XZR).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all registers on the clk edge where it is sampled high.
- write_enable  input  1  commits write_data to write_reg at the next rising clk edge.
- write_reg  input  $clog2(DEPTH)  destination register index.
- write_data  input  WIDTH  data to write.
- byte_en  input  WIDTH/8  per-byte write mask; bit k covers bits [8k+7:8k].
- read_reg  input  NUM_READ x $clog2(DEPTH)  source index for each read port.
- read_data  output  NUM_READ x WIDTH  read result for each read port.

Behaviour:
- One clock; reset is synchronous and active-high. There is no asynchronous path into the storage.
- Reset state:
  - At a rising edge with reset=1, every register becomes 0.
  - reset dominates write_enable in the same cycle; the write is dropped.
  - Consequently, every read_data reads 0 from the first cycle after reset.
- Write:
  - At a rising edge with reset=0, write_enable=1, write_reg != ZERO_REG and write_reg < DEPTH, byte k of register[write_reg] takes write_data byte k where byte_en[k]=1.
  - Bytes with byte_en[k]=0 hold their value.
  - byte_en all-zero means no state change.
- Ignored writes (silently dropped, no error flag):
  - write_reg == ZERO_REG.
  - write_reg >= DEPTH (only possible when DEPTH is not a power of two).
- Hold: with no write, every register holds indefinitely. This uses a recirculating mux per register, as in the existing register element.
- Read:
  - Purely combinational, zero-cycle latency from read_reg to read_data.
  - read_data[p] = register[read_reg[p]].
  - read_reg[p] == ZERO_REG or >= DEPTH yields 0.
  - Ports are fully independent; any number of ports may address the same register.
- Write-to-read latency without bypass:
  - New data appears on read_data from the cycle after the write edge.
  - A same-cycle read of the register being written returns the old value.
- Reset mid-operation: any write presented in a reset cycle is lost. The write pipeline holds no residual state because it is single-cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose read_reg equals write_reg, while write_enable=1, reset=0 and the index is a legal non-zero register, returns the merged value in the same cycle.
  - The merged value takes write_data bytes where byte_en=1 and stored bytes elsewhere.
  - Zero register and out-of-range indices still read 0.
- Undefined: no forwarding; the read returns the pre-write value as described above.
- The bypass adds only combinational logic; it does not change write timing.

Decomposition:
- Package regfile_pkg:
  - Constants: REG_WIDTH=64, REG_DEPTH=32, REG_ZERO=31.
  - Derived IDX_W=$clog2(REG_DEPTH).
  - Typedefs: reg_idx_t, reg_data_t, byte_en_t.
- Sub-module register_be:
  - One WIDTH-bit register with synchronous reset and per-byte enable.
  - Built from D flip-flops and 2:1 hold muxes.
  - Instantiated DEPTH-1 times via generate; the zero register has no storage.
- Write decode: a one-hot decoder from write_reg gated by write_enable, done inline.
- Read muxing: one DEPTH:1 mux per read port, done inline.

Test Plan:
- Reset: preload X0=0xDEADBEEF_CAFEF00D, assert reset for 1 cycle → read_data on X0 and all ports = 0 next cycle.
- Write/read: write X5=0x0123_4567_89AB_CDEF with byte_en=0xFF → X5 reads the value on both ports the next cycle; a same-cycle read returns 0 (bypass undefined).
- Zero register: write X31=0xFFFF_FFFF_FFFF_FFFF with write_enable=1 → read X31 = 0; all other registers unchanged.
- Byte enable: X7=0x1111_1111_1111_1111, write 0xAAAA_AAAA_AAAA_AAAA with byte_en=0x0F → X7 = 0x1111_1111_AAAA_AAAA.
- Reset priority: reset=1 and write X3=0x55 in the same cycle → X3 reads 0 afterwards; a write with write_enable=0 leaves the register unchanged.
- Bypass (REGFILE_BYPASS_EN): X9=0x0, write X9=0x77 with byte_en=0x01 while reading X9 → read_data = 0x77 in the same cycle. Without the macro → 0x0 in the same cycle, 0x77 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, default geometry and index/data types for the CPU integer register file.
package regfile_pkg;

   localparam int REG_WIDTH = 64;
   localparam int REG_DEPTH = 32;
   localparam int REG_ZERO  = 31;
   localparam int IDX_W     = $clog2(REG_DEPTH);

   typedef logic [IDX_W-1:0]       reg_idx_t;
   typedef logic [REG_WIDTH-1:0]   reg_data_t;
   typedef logic [REG_WIDTH/8-1:0] byte_en_t;

endpackage

// File: rtl/regfile_param_register_be.sv
// One WIDTH-bit register with synchronous active-high clear and per-byte write enable.
// Unwritten bytes recirculate through a 2:1 hold mux in front of each flop.
module register_be
   import regfile_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [WIDTH/8-1:0] byte_en,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   q
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] nxt;

   for (genvar k = 0; k < NB; k++) begin : g_byte
      assign nxt[8*k +: 8] = (enable && byte_en[k]) ? d[8*k +: 8] : q[8*k +: 8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/regfile_param.sv
// Multi-port register file: one byte-masked write port, NUM_READ zero-latency read ports, hardwired zero register.
// Defining REGFILE_BYPASS_EN forwards the in-flight write (merged by byte_en) to matching read ports in the same cycle.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int WIDTH    = REG_WIDTH,
   parameter int DEPTH    = REG_DEPTH,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = REG_ZERO
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              write_enable,
   input  logic [$clog2(DEPTH)-1:0]          write_reg,
   input  logic [WIDTH-1:0]                  write_data,
   input  logic [WIDTH/8-1:0]                byte_en,
   input  logic [NUM_READ*$clog2(DEPTH)-1:0] read_reg,
   output logic [NUM_READ*WIDTH-1:0]         read_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int NB = WIDTH / 8;

   logic             wr_legal;
   logic [DEPTH-1:0] wr_sel;
   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] rd   [NUM_READ];

   // Zero register and out-of-range indices never produce a select, so those writes vanish.
   always_comb begin
      wr_legal = write_enable && (int'(write_reg) < DEPTH) && (int'(write_reg) != ZERO_REG);
      wr_sel   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_legal && (int'(write_reg) == i)) begin
            wr_sel[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      if (g == ZERO_REG) begin : g_zero
         logic unused_sel;
         assign unused_sel = wr_sel[g];
         assign regs[g]    = '0;
      end else begin : g_store
         register_be #(
            .WIDTH (WIDTH)
         ) u_reg (
            .clk     (clk),
            .reset   (reset),
            .enable  (wr_sel[g]),
            .byte_en (byte_en),
            .d       (write_data),
            .q       (regs[g])
         );
      end
   end

`ifdef REGFILE_BYPASS_EN
   function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_val,
                                                    input logic [WIDTH-1:0] new_val,
                                                    input logic [NB-1:0]    mask);
      logic [WIDTH-1:0] res;
      res = old_val;
      for (int k = 0; k < NB; k++) begin
         if (mask[k]) begin
            res[8*k +: 8] = new_val[8*k +: 8];
         end
      end
      return res;
   endfunction
`endif

   always_comb begin
      for (int p = 0; p < NUM_READ; p++) begin
         rd[p] = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (int'(read_reg[p*IW +: IW]) == i) begin
               rd[p] = regs[i];
            end
         end
`ifdef REGFILE_BYPASS_EN
         // wr_legal already excludes the zero register and out-of-range indices.
         if (wr_legal && !reset && (read_reg[p*IW +: IW] == write_reg)) begin
            rd[p] = merge_bytes(rd[p], write_data, byte_en);
         end
`endif
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      assign read_data[p*WIDTH +: WIDTH] = rd[p];
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed and randomized check of regfile_param against an array-of-registers reference model.
module tb_regfile_param;

   localparam int W  = 64;
   localparam int D  = 32;
   localparam int NR = 2;
   localparam int Z  = 31;
   localparam int IW = 5;

   logic           clk = 1'b0;
   logic           reset;
   logic           write_enable;
   logic [IW-1:0]  write_reg;
   logic [W-1:0]   write_data;
   logic [7:0]     byte_en;
   logic [NR*IW-1:0] read_reg;
   logic [NR*W-1:0]  read_data;

   logic [W-1:0] model [D];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_param #(
      .WIDTH    (W),
      .DEPTH    (D),
      .NUM_READ (NR),
      .ZERO_REG (Z)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .write_enable (write_enable),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .byte_en      (byte_en),
      .read_reg     (read_reg),
      .read_data    (read_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // What a read of idx must return right now, given current inputs and committed state.
   function automatic logic [63:0] expect_read(input logic [4:0] idx);
      logic [63:0] v;
      if (idx == 5'(Z)) return '0;
      v = model[idx];
`ifdef REGFILE_BYPASS_EN
      if (!reset && write_enable && write_reg == idx)
         for (int k = 0; k < 8; k++)
            if (byte_en[k]) v[8*k +: 8] = write_data[8*k +: 8];
`endif
      return v;
   endfunction

   task automatic apply(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [7:0] be,
                        input logic [4:0] r0, input logic [4:0] r1);
      reset        = rst;
      write_enable = we;
      write_reg    = wr;
      write_data   = wd;
      byte_en      = be;
      read_reg     = {r1, r0};
      #1;
   endtask

   task automatic commit();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < D; i++) model[i] = '0;
      end else if (write_enable && write_reg != 5'(Z)) begin
         for (int k = 0; k < 8; k++)
            if (byte_en[k]) model[write_reg][8*k +: 8] = write_data[8*k +: 8];
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [7:0] be,
                        input logic [4:0] r0, input logic [4:0] r1, input string tag);
      apply(rst, we, wr, wd, be, r0, r1);
      check($sformatf("%s_p0_r%0d", tag, r0), read_data[63:0],   expect_read(r0));
      check($sformatf("%s_p1_r%0d", tag, r1), read_data[127:64], expect_read(r1));
      commit();
   endtask

   task automatic peek(input logic [4:0] r, input string tag, input logic [63:0] exp);
      apply(1'b0, 1'b0, 5'd0, '0, '0, r, r);
      check($sformatf("%s_p0_r%0d", tag, r), read_data[63:0],   exp);
      check($sformatf("%s_p1_r%0d", tag, r), read_data[127:64], exp);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] wr, r0, r1;
      logic [7:0] be;
      logic [63:0] same_exp;

      reset = 1'b1; write_enable = 1'b0; write_reg = '0; write_data = '0;
      byte_en = '0; read_reg = '0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < D; i++) model[i] = '0;

      for (int i = 0; i < D; i++) peek(5'(i), "rst_state", 64'h0);

      // Preload then clear
      drive(1'b0, 1'b1, 5'd0, 64'hDEADBEEF_CAFEF00D, 8'hFF, 5'd0, 5'd1, "pre");
      peek(5'd0, "x0_loaded", 64'hDEADBEEF_CAFEF00D);
      drive(1'b1, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0, "rst_pulse");
      peek(5'd0, "x0_cleared", 64'h0);

      // Full write, same-cycle read sees old (or merged with bypass)
      apply(1'b0, 1'b1, 5'd5, 64'h01234567_89ABCDEF, 8'hFF, 5'd5, 5'd5);
`ifdef REGFILE_BYPASS_EN
      same_exp = 64'h01234567_89ABCDEF;
`else
      same_exp = 64'h0;
`endif
      check("x5_same_cycle", read_data[63:0], same_exp);
      commit();
      peek(5'd5, "x5_next", 64'h01234567_89ABCDEF);

      // Zero register ignores writes, nothing else disturbed
      drive(1'b0, 1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 5'd31, 5'd5, "xzr_wr");
      peek(5'd31, "xzr", 64'h0);
      for (int i = 0; i < Z; i++) peek(5'(i), "xzr_others", (i == 5) ? 64'h01234567_89ABCDEF : 64'h0);

      // Byte lanes
      drive(1'b0, 1'b1, 5'd7, 64'h11111111_11111111, 8'hFF, 5'd7, 5'd0, "x7_init");
      drive(1'b0, 1'b1, 5'd7, 64'hAAAAAAAA_AAAAAAAA, 8'h0F, 5'd7, 5'd7, "x7_be");
      peek(5'd7, "x7_lo_bytes", 64'h11111111_AAAAAAAA);
      drive(1'b0, 1'b1, 5'd7, 64'h0, 8'h00, 5'd7, 5'd7, "x7_be0");
      peek(5'd7, "x7_be_zero", 64'h11111111_AAAAAAAA);

      // Reset beats a simultaneous write; disabled writes do nothing
      drive(1'b0, 1'b1, 5'd3, 64'h0000_0000_0000_00AA, 8'hFF, 5'd3, 5'd3, "x3_pre");
      drive(1'b1, 1'b1, 5'd3, 64'h55, 8'hFF, 5'd3, 5'd7, "x3_rst");
      peek(5'd3, "x3_after_rst", 64'h0);
      peek(5'd7, "x7_after_rst", 64'h0);
      drive(1'b0, 1'b0, 5'd3, 64'h99, 8'hFF, 5'd3, 5'd3, "x3_we0");
      peek(5'd3, "x3_we0_hold", 64'h0);

      // Forwarding case on a zeroed register
      apply(1'b0, 1'b1, 5'd9, 64'h77, 8'h01, 5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
      same_exp = 64'h77;
`else
      same_exp = 64'h0;
`endif
      check("x9_same_cycle", read_data[63:0], same_exp);
      check("x9_same_cycle_p1", read_data[127:64], same_exp);
      commit();
      peek(5'd9, "x9_next", 64'h77);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         wr = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       be = 8'h00;
            1:       be = 8'hFF;
            default: be = 8'($urandom);
         endcase
         r0 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), wr,
               {32'($urandom), 32'($urandom)}, be, r0, r1, "rnd");
      end

      for (int i = 0; i < D; i++) peek(5'(i), "final", (i == Z) ? 64'h0 : model[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
